// File: rtl/countdown_bcd_pkg.sv
// Shared constants for the BCD countdown timer and its start/pause controller.
// Holds the FSM state encodings and the count-enable level values.
package countdown_bcd_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cd_state_e;

    localparam logic CE_COUNT = 1'b1;
    localparam logic CE_PAUSE = 1'b0;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/countdown_bcd_dec_digit.sv
// One BCD digit of a down-counter: decrement with borrow chaining.
// Purely combinational; the owning module registers the result.
module bcd_dec_digit
    import countdown_bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_dec,
    output logic       borrow_out,
    output logic       is_zero
);

    // Decrement when asked; 0 rolls to 9 and passes a borrow upward.
    always_comb begin
        is_zero    = (digit == 4'd0);
        borrow_out = borrow_in & is_zero;
        digit_dec  = digit;
        if (borrow_in) begin
            if (is_zero) begin
                digit_dec = BCD_MAX;
            end else begin
                digit_dec = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_bcd.sv
// Two-digit BCD countdown timer with HOLD/RUN/DONE control.
// Ticks decrement only while running; reload restores the start value.
module countdown_bcd
    import countdown_bcd_pkg::*;
#(
    parameter logic [3:0] START_TENS = 4'd3,
    parameter logic [3:0] START_ONES = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       count_enable,
    input  logic       tick,
    input  logic       reload,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       done,
    output logic [1:0] state_o
);

    cd_state_e  state_q;
    cd_state_e  state_d;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic [3:0] tens_d;
    logic [3:0] ones_d;
    logic       done_d;

    logic       dec_en;
    logic [3:0] ones_dec;
    logic [3:0] tens_dec;
    logic       ones_borrow;
    logic       tens_borrow;
    logic       ones_zero;
    logic       tens_zero;
    logic       value_zero;
    logic       value_one;

    assign value_zero = tens_zero & ones_zero;
    assign value_one  = tens_zero & (ones_q == 4'd1);

    // A tick is accepted only while running, enabled and not overridden.
    assign dec_en = (state_q == ST_RUN)
                  & (count_enable == CE_COUNT)
                  & tick
                  & ~reload
                  & ~value_zero;

    bcd_dec_digit u_ones (
        .digit      (ones_q),
        .borrow_in  (dec_en),
        .digit_dec  (ones_dec),
        .borrow_out (ones_borrow),
        .is_zero    (ones_zero)
    );

    bcd_dec_digit u_tens (
        .digit      (tens_q),
        .borrow_in  (ones_borrow),
        .digit_dec  (tens_dec),
        .borrow_out (tens_borrow),
        .is_zero    (tens_zero)
    );

    // Next state and next digits; reload overrides everything else.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (reload) begin
            state_d = ST_HOLD;
            tens_d  = START_TENS;
            ones_d  = START_ONES;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (count_enable == CE_COUNT) begin
                        state_d = value_zero ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (count_enable == CE_PAUSE) begin
                        state_d = ST_HOLD;
                    end else if (value_zero) begin
                        state_d = ST_DONE;
                    end else if (tick) begin
                        tens_d = tens_borrow ? tens_q : tens_dec;
                        ones_d = ones_dec;
                        if (value_one) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end
                default: begin
                    state_d = ST_HOLD;
                    tens_d  = START_TENS;
                    ones_d  = START_ONES;
                end
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    // State, digit and done registers; reset loads the start value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HOLD;
            tens_q  <= START_TENS;
            ones_q  <= START_ONES;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            done    <= done_d;
        end
    end

    assign digit1  = tens_q;
    assign digit0  = ones_q;
    assign state_o = state_q;

endmodule
